sm_ahb_ram: RTL and testbench
=============================

# sm_ahb_ram

AHB-Lite slave RAM with a configurable number of wait states, placed directly downstream of the on-chip matrix's AHB-Lite host port. It serves as the "slow" external memory behind the matrix's address range 0x20000000 and up, and gives the matrix's HREADY-driven response path a real multi-cycle slave to exercise. Single-transfer AHB-Lite, word accesses only, OKAY-only responses.

## Interface
- SIZE, 64: memory depth in 32-bit words; power of two, at least 2. AW = log2(SIZE).
- WAIT, 2: wait states inserted in every data phase, 0..15.
- HCLK  in  1  clock; all state updates on the rising edge.
- HRESETn  in  1  reset, asynchronous, active-low.
- HSEL  in  1  slave select.
- HWRITE  in  1  1 = write, 0 = read; sampled in the address phase.
- HTRANS  in  2  transfer type; only bit 1 (NONSEQ/SEQ) is significant.
- HADDR  in  32  byte address; sampled in the address phase.
- HWDATA  in  32  write data; sampled on the last data-phase cycle.
- HRDATA  out  32  read data; valid while HREADY=1 in a read data phase.
- HREADY  out  1  transfer-done / slave ready.
- HRESP  out  1  response; tied 0 (OKAY).

## Operation
- Accept: an address phase is accepted on an edge where HSEL & HTRANS[1] & HREADY = 1.
- On accept, register: index = HADDR[AW+1:2], write flag = HWRITE, counter = WAIT.
- HADDR[31:AW+2] and HADDR[1:0] are ignored. Addresses alias modulo SIZE words. No error responses are generated.
- States:
  - IDLE: no data phase pending; HREADY=1.
  - BUSY: data phase pending, counter>0; HREADY=0; counter decrements by 1 per cycle.
  - LAST: data phase pending, counter=0; HREADY=1; the transfer completes at this edge.
- Transitions:
  - IDLE→BUSY on accept with WAIT>0; IDLE→LAST on accept with WAIT=0.
  - BUSY→LAST when counter reaches 0.
  - LAST→LAST/BUSY on a back-to-back accept; LAST→IDLE otherwise.
- Read: the word at the registered index is loaded into a data register so HRDATA is valid in LAST. HRDATA holds its last value at all other times.
- Write: mem[index] <= HWDATA on the LAST edge only.
- Hazard: a LAST write and an accepted read at the same index on the same edge → the read returns the new HWDATA (forwarded), not the stale word.
- Non-transfers: HSEL=0 or HTRANS IDLE/BUSY while HREADY=1 → no state change, no memory access.
- Memory contents are not reset and are X until written.

## Timing
- Reset values: state=IDLE, HREADY=1, HRESP=0, HRDATA=0, counter=0, no pending write.
- Latency: address phase at cycle T → data phase occupies T+1..T+1+WAIT. HREADY=0 for WAIT cycles, then 1 for one cycle.
- Throughput: one transfer per WAIT+1 cycles with back-to-back NONSEQ.
- Pipelining: the next address phase overlaps the current LAST cycle. An accept is impossible while BUSY (HREADY=0).
- Input stability: HADDR, HWRITE and HTRANS may change during BUSY without effect. HWDATA is sampled only in LAST.
- HRESETn asserted mid-transfer: the pending transfer is dropped, no memory write occurs, and outputs return to reset values immediately (asynchronously).

## Test plan
- Reset: hold HRESETn=0 with random inputs → HREADY=1, HRESP=0, HRDATA=0; no memory writes.
- WAIT=2, write 0xDEADBEEF to 0x20000010, then read 0x20000010 → each data phase shows HREADY 0,0,1; read returns 0xDEADBEEF.
- WAIT=0, back-to-back write 0x11111111 @0x20000004 then read 0x20000004 accepted in the write's LAST cycle → forwarded read returns 0x11111111, no stall.
- SIZE=64: write 0xA5A5A5A5 @0x20000000, read 0x20000100 (alias) and 0x20000003 (low bits ignored) → both return 0xA5A5A5A5.
- HSEL=1, HTRANS=IDLE for 5 cycles, then HSEL=0 with HTRANS=NONSEQ → HREADY stays 1; memory and HRDATA unchanged.
- WAIT=3 write in progress, pulse HRESETn low during the 2nd BUSY cycle → HREADY=1 at once; reading the target address afterwards returns the prior contents.

Source files
------------

// File: rtl/sm_ahb_ram_if.sv
// AHB-Lite signal bundle between the matrix host port and the slow RAM slave.
// Bus signal names follow the AHB-Lite protocol so traces line up with the matrix.
interface sm_ahb_ram_if;
   logic        HSEL;
   logic        HWRITE;
   logic [1:0]  HTRANS;
   logic [31:0] HADDR;
   logic [31:0] HWDATA;
   logic [31:0] HRDATA;
   logic        HREADY;
   logic        HRESP;

   modport master (
      output HSEL, HWRITE, HTRANS, HADDR, HWDATA,
      input  HRDATA, HREADY, HRESP
   );

   modport slave (
      input  HSEL, HWRITE, HTRANS, HADDR, HWDATA,
      output HRDATA, HREADY, HRESP
   );
endinterface

// File: rtl/sm_ahb_ram.sv
// AHB-Lite word RAM with WAIT wait states per data phase, OKAY-only responses.
// Single transfers; the next address phase may overlap the current LAST cycle.
module sm_ahb_ram #(
   parameter int unsigned SIZE = 64,
   parameter int unsigned WAIT = 2
) (
   input  logic            HCLK,
   input  logic            HRESETn,
   sm_ahb_ram_if.slave     bus
);

   localparam int unsigned AW       = $clog2(SIZE);
   localparam logic [3:0]  WAIT_CNT = 4'(WAIT);

   typedef enum logic [1:0] {StIdle, StBusy, StLast} state_t;

   logic [31:0]   r_mem [SIZE];
   state_t        r_state;
   logic [3:0]    r_cnt;
   logic [AW-1:0] r_idx;
   logic          r_write;
   logic          r_hready;
   logic [31:0]   r_hrdata;

   logic          w_accept;
   logic [AW-1:0] w_idx;
   logic          w_last_wr;
   logic [31:0]   w_fwd_word;
   logic          w_unused;

   assign w_accept  = bus.HSEL & bus.HTRANS[1] & r_hready;
   assign w_idx     = bus.HADDR[AW+1:2];
   assign w_last_wr = (r_state == StLast) & r_write;
   // A read accepted under a completing write to the same word sees the new data.
   assign w_fwd_word = (w_last_wr && (r_idx == w_idx)) ? bus.HWDATA : r_mem[w_idx];
   assign w_unused   = ^{bus.HADDR[31:AW+2], bus.HADDR[1:0], bus.HTRANS[0]};

   assign bus.HRDATA = r_hrdata;
   assign bus.HREADY = r_hready;
   assign bus.HRESP  = 1'b0;

   always_ff @(posedge HCLK) begin
      if (w_last_wr) begin
         r_mem[r_idx] <= bus.HWDATA;
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_state  <= StIdle;
         r_cnt    <= 4'd0;
         r_idx    <= '0;
         r_write  <= 1'b0;
         r_hready <= 1'b1;
         r_hrdata <= 32'd0;
      end else begin
         case (r_state)
            StIdle, StLast: begin
               if (w_accept) begin
                  r_idx   <= w_idx;
                  r_write <= bus.HWRITE;
                  r_cnt   <= WAIT_CNT;
                  if (WAIT_CNT == 4'd0) begin
                     r_state  <= StLast;
                     r_hready <= 1'b1;
                     if (!bus.HWRITE) begin
                        r_hrdata <= w_fwd_word;
                     end
                  end else begin
                     r_state  <= StBusy;
                     r_hready <= 1'b0;
                  end
               end else begin
                  r_state  <= StIdle;
                  r_write  <= 1'b0;
                  r_hready <= 1'b1;
               end
            end
            StBusy: begin
               r_cnt <= r_cnt - 4'd1;
               if (r_cnt == 4'd1) begin
                  r_state  <= StLast;
                  r_hready <= 1'b1;
                  // Any earlier write to this word has already committed by now.
                  if (!r_write) begin
                     r_hrdata <= r_mem[r_idx];
                  end
               end
            end
            default: begin
               r_state  <= StIdle;
               r_hready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sm_ahb_ram.sv
// Directed bench for sm_ahb_ram: three instances (WAIT 2, 0, 3) on one clock/reset,
// read data checked against a queue of expected words pushed at each read address phase.
module tb_sm_ahb_ram;

   logic        HCLK;
   logic        HRESETn;

   logic        t_hsel   [3];
   logic        t_hwrite [3];
   logic [1:0]  t_htrans [3];
   logic [31:0] t_haddr  [3];
   logic [31:0] t_hwdata [3];
   logic [31:0] w_hrdata [3];
   logic        w_hready [3];
   logic        w_hresp  [3];

   int          waits    [3];
   logic [31:0] sb_q     [$];
   int          n_cmp;
   int          n_err;

   sm_ahb_ram_if bus0 ();
   sm_ahb_ram_if bus1 ();
   sm_ahb_ram_if bus2 ();

   sm_ahb_ram #(.SIZE(64), .WAIT(2)) u_dut0 (.HCLK(HCLK), .HRESETn(HRESETn), .bus(bus0));
   sm_ahb_ram #(.SIZE(64), .WAIT(0)) u_dut1 (.HCLK(HCLK), .HRESETn(HRESETn), .bus(bus1));
   sm_ahb_ram #(.SIZE(64), .WAIT(3)) u_dut2 (.HCLK(HCLK), .HRESETn(HRESETn), .bus(bus2));

   assign bus0.HSEL = t_hsel[0];  assign bus0.HWRITE = t_hwrite[0];
   assign bus0.HTRANS = t_htrans[0];  assign bus0.HADDR = t_haddr[0];
   assign bus0.HWDATA = t_hwdata[0];
   assign bus1.HSEL = t_hsel[1];  assign bus1.HWRITE = t_hwrite[1];
   assign bus1.HTRANS = t_htrans[1];  assign bus1.HADDR = t_haddr[1];
   assign bus1.HWDATA = t_hwdata[1];
   assign bus2.HSEL = t_hsel[2];  assign bus2.HWRITE = t_hwrite[2];
   assign bus2.HTRANS = t_htrans[2];  assign bus2.HADDR = t_haddr[2];
   assign bus2.HWDATA = t_hwdata[2];

   assign w_hrdata[0] = bus0.HRDATA;  assign w_hready[0] = bus0.HREADY;
   assign w_hresp[0]  = bus0.HRESP;
   assign w_hrdata[1] = bus1.HRDATA;  assign w_hready[1] = bus1.HREADY;
   assign w_hresp[1]  = bus1.HRESP;
   assign w_hrdata[2] = bus2.HRDATA;  assign w_hready[2] = bus2.HREADY;
   assign w_hresp[2]  = bus2.HRESP;

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach summary");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic bus_idle(input int d);
      t_hsel[d]   = 1'b0;
      t_htrans[d] = 2'b00;
      t_hwrite[d] = 1'b0;
      t_haddr[d]  = 32'd0;
      t_hwdata[d] = 32'd0;
   endtask

   task automatic sb_pop_check(input string tag, input int d);
      logic [31:0] exp;
      if (sb_q.size() == 0) begin
         n_cmp++;
         n_err++;
         $error("FAIL %s: observed %h expected <queued word>", tag, w_hrdata[d]);
      end else begin
         exp = sb_q.pop_front();
         check(tag, w_hrdata[d], exp);
      end
   endtask

   // Single transfer; for reads, data is the expected word. Returns in the LAST cycle.
   task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                       input logic [31:0] data, input string tag);
      @(negedge HCLK);
      t_hsel[d]   = 1'b1;
      t_htrans[d] = 2'b10;
      t_hwrite[d] = wr;
      t_haddr[d]  = addr;
      t_hwdata[d] = ~data;
      if (!wr) sb_q.push_back(data);
      @(negedge HCLK);
      t_hsel[d]   = 1'b0;
      t_htrans[d] = 2'b00;
      t_hwrite[d] = ~wr;
      t_haddr[d]  = $urandom;
      for (int k = 0; k < waits[d]; k++) begin
         check({tag, "/wait"}, 32'(w_hready[d]), 32'd0);
         @(negedge HCLK);
      end
      check({tag, "/ready"}, 32'(w_hready[d]), 32'd1);
      t_hwdata[d] = data;
      if (!wr) sb_pop_check({tag, "/rdata"}, d);
   endtask

   initial begin
      n_cmp    = 0;
      n_err    = 0;
      waits[0] = 2;
      waits[1] = 0;
      waits[2] = 3;
      HRESETn  = 1'b0;
      for (int d = 0; d < 3; d++) bus_idle(d);

      // Reset held with random bus activity.
      for (int c = 0; c < 4; c++) begin
         @(negedge HCLK);
         for (int d = 0; d < 3; d++) begin
            t_hsel[d]   = 1'($urandom);
            t_htrans[d] = 2'($urandom);
            t_hwrite[d] = 1'($urandom);
            t_haddr[d]  = $urandom;
            t_hwdata[d] = $urandom;
         end
         #1;
         for (int d = 0; d < 3; d++) begin
            check("rst/hready", 32'(w_hready[d]), 32'd1);
            check("rst/hresp",  32'(w_hresp[d]),  32'd0);
            check("rst/hrdata", w_hrdata[d],      32'd0);
         end
      end
      @(negedge HCLK);
      for (int d = 0; d < 3; d++) bus_idle(d);
      HRESETn = 1'b1;

      // WAIT=2 write then read.
      xfer(0, 1'b1, 32'h2000_0010, 32'hDEAD_BEEF, "w2/wr");
      xfer(0, 1'b0, 32'h2000_0010, 32'hDEAD_BEEF, "w2/rd");

      // WAIT=0 back-to-back write then read of the same word (forwarding).
      xfer(1, 1'b1, 32'h2000_0004, 32'h2222_2222, "b2b/pre");
      @(negedge HCLK);
      t_hsel[1]   = 1'b1;
      t_htrans[1] = 2'b10;
      t_hwrite[1] = 1'b1;
      t_haddr[1]  = 32'h2000_0004;
      t_hwdata[1] = 32'hEEEE_EEEE;
      @(negedge HCLK);
      check("b2b/wr_ready", 32'(w_hready[1]), 32'd1);
      t_hwdata[1] = 32'h1111_1111;
      t_hwrite[1] = 1'b0;
      sb_q.push_back(32'h1111_1111);
      @(negedge HCLK);
      check("b2b/rd_ready", 32'(w_hready[1]), 32'd1);
      sb_pop_check("b2b/fwd", 1);
      bus_idle(1);
      xfer(1, 1'b0, 32'h2000_0004, 32'h1111_1111, "b2b/mem");

      // Aliasing and ignored byte-offset bits.
      xfer(0, 1'b1, 32'h2000_0000, 32'hA5A5_A5A5, "alias/wr");
      xfer(0, 1'b0, 32'h2000_0100, 32'hA5A5_A5A5, "alias/rd100");
      xfer(0, 1'b0, 32'h2000_0003, 32'hA5A5_A5A5, "alias/rd003");

      // Non-transfers: selected IDLE, then unselected NONSEQ writes.
      for (int c = 0; c < 8; c++) begin
         @(negedge HCLK);
         t_hsel[0]   = (c < 5);
         t_htrans[0] = (c < 5) ? 2'b00 : 2'b10;
         t_hwrite[0] = 1'b1;
         t_haddr[0]  = 32'h2000_0000;
         t_hwdata[0] = 32'h0BAD_0BAD;
         @(negedge HCLK);
         check("idle/hready", 32'(w_hready[0]), 32'd1);
         check("idle/hrdata", w_hrdata[0], 32'hA5A5_A5A5);
      end
      bus_idle(0);
      xfer(0, 1'b0, 32'h2000_0000, 32'hA5A5_A5A5, "idle/mem");

      // WAIT=3 write aborted by reset in its second BUSY cycle.
      xfer(2, 1'b1, 32'h2000_0020, 32'hCAFE_F00D, "abort/pre");
      @(negedge HCLK);
      t_hsel[2]   = 1'b1;
      t_htrans[2] = 2'b10;
      t_hwrite[2] = 1'b1;
      t_haddr[2]  = 32'h2000_0020;
      t_hwdata[2] = 32'h0BAD_BEEF;
      @(negedge HCLK);
      t_hsel[2]   = 1'b0;
      t_htrans[2] = 2'b00;
      check("abort/busy1", 32'(w_hready[2]), 32'd0);
      @(negedge HCLK);
      check("abort/busy2", 32'(w_hready[2]), 32'd0);
      #1 HRESETn = 1'b0;
      #1;
      check("abort/hready", 32'(w_hready[2]), 32'd1);
      check("abort/hrdata0", w_hrdata[0], 32'd0);
      @(negedge HCLK);
      HRESETn = 1'b1;
      xfer(2, 1'b0, 32'h2000_0020, 32'hCAFE_F00D, "abort/mem");

      @(negedge HCLK);
      check("sb/empty", 32'(sb_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
